instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the block-oriented instruction memory.
- CPU side: 10-bit byte PC and a 32-bit instruction out, with a busywait stall.
- Memory side: initiator of the instruction memory's read/busywait protocol. Issues a 6-bit block address and receives 128-bit (16-byte) blocks.
- Hits return combinationally in the same cycle; misses stall the CPU until the block is refilled.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (index width = log2 = 3).
- BLOCK_BYTES, 16, bytes per line; fixed to match the 128-bit memory block.
- ADDR_W, 10, CPU byte-address width (1024-byte instruction space).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- cpu_read  in  1  fetch request; high whenever the CPU wants an instruction.
- cpu_address  in  10  byte PC; bits [1:0] ignored.
- cpu_instruction  out  32  addressed instruction word.
- cpu_busywait  out  1  CPU stall.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  6  block address {tag, index}.
- mem_readdata  in  128  block data, byte 0 in [7:0].
- mem_busywait  in  1  memory busy; rises with mem_read, falls when mem_readdata is valid.

Behaviour:
- Address split:
  - tag = cpu_address[9:7]
  - index = cpu_address[6:4]
  - word offset = cpu_address[3:2]
- Per-line storage: valid bit, 3-bit tag, 128-bit data.
- Word select: offset 0 → data[31:0], 1 → [63:32], 2 → [95:64], 3 → [127:96].
- hit = valid[index] && (tag_array[index] == tag). Combinational from cpu_address.
- cpu_instruction = selected word when hit, else 32'h0.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE:
    - cpu_busywait = cpu_read && !hit; mem_read = 0.
    - On posedge with cpu_read && !hit: latch {tag, index} into miss_addr and go to MEM_READ.
  - MEM_READ:
    - mem_read = 1; mem_address = miss_addr; cpu_busywait = 1.
    - Stay while mem_busywait = 1.
    - On the first posedge with mem_busywait = 0, go to UPDATE.
    - The memory raises busywait in the same delta as mem_read, so no false completion occurs on the entry edge.
  - UPDATE:
    - mem_read = 0; cpu_busywait = 1.
    - At posedge: write mem_readdata to data[miss_addr index], set tag, set valid = 1, go to IDLE.
    - The following IDLE cycle hits and cpu_busywait drops.
- Miss latency: 1 cycle (IDLE→MEM_READ) + memory latency (≈640 ns from the sampling edge) + 1 cycle UPDATE + combinational hit.
- Hit latency: 0 cycles, no stall.
- cpu_read low: cpu_busywait = 0, no refill started. A refill already in MEM_READ/UPDATE completes regardless.
- cpu_address changes during a refill: ignored. miss_addr is held; after UPDATE the new address is evaluated normally, which may cause another miss.
- Conflict miss: a different tag at the same index overwrites the line. No write-back; the cache is read-only.
- Reset asserted (low):
  - All valid bits cleared; state = IDLE.
  - mem_read = 0, cpu_busywait = 0 (while cpu_read is low), cpu_instruction = 0.
  - Data and tag arrays are not cleared.
- Reset mid-refill: the request is dropped and the late mem_readdata is never written. After reset, mem_busywait must be low before a new miss is accepted; IDLE waits while mem_busywait = 1.
- Simultaneous reset release and cpu_read: the first posedge after release with a miss enters MEM_READ.

Decomposition:
- Shared package holds:
  - Address field widths and positions: TAG_W = 3, INDEX_W = 3, OFFSET_LSB = 2.
  - BLOCK_W = 128.
  - FSM state encoding: IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2.
- One natural sub-module: icache_word_select. Combinational 4:1 mux of a 128-bit block by 2-bit offset to a 32-bit word; reusable by the data cache.

Test Plan:
- Cold miss: reset, cpu_read = 1, cpu_address = 10'h000. Required:
  - cpu_busywait = 1; mem_read = 1 with mem_address = 6'h00.
  - After mem_busywait falls plus UPDATE, cpu_instruction = 32'h00030014 and cpu_busywait = 0.
- Same-block hits: after the cold miss, step addresses 10'h004, 10'h008, 10'h00C. Required:
  - Instructions 32'h00040021, 32'h00010031, 32'h0A000103 each cycle.
  - No mem_read; cpu_busywait stays 0.
- Sequential block miss: address 10'h010. Required:
  - mem_address = 6'h01.
  - cpu_instruction = 32'h0A000401 after refill.
- Conflict miss: load 10'h000, then 10'h080 (same index 0, tag 1), then 10'h000 again. Required: three refills, with mem_address 6'h00, 6'h08, 6'h00.
- Reset mid-refill: assert reset while in MEM_READ for 10'h020. Required:
  - mem_read and cpu_busywait go low immediately.
  - No line becomes valid.
  - A re-fetch of 10'h020 performs a full refill with mem_address = 6'h02.
- Address churn during stall: change cpu_address from 10'h010 to 10'h030 while in MEM_READ. Required:
  - The block 6'h01 refill completes first.
  - A second miss then fetches 6'h03.

Source files
------------

// File: rtl/instruction_cache_pkg.sv
// Shared constants and state encoding for the instruction cache and its helpers.
// Address layout: {tag[9:7], index[6:4], word[3:2], byte[1:0]}.
package instruction_cache_pkg;

    localparam int ADDR_W     = 10;
    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_LSB = 2;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_word_select.sv
// Picks one 32-bit word out of a 128-bit cache block; word 0 sits in the low bits.
module icache_word_select
    import instruction_cache_pkg::*;
(
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [1:0]         offset_i,
    output logic [WORD_W-1:0]  word_o
);

    assign word_o = block_i[offset_i * WORD_W +: WORD_W];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally;
// misses stall the CPU through MEM_READ and UPDATE while the block is refilled.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 16,
    parameter int ADDR_W      = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic [ADDR_W-1:0]     cpu_address,
    output logic [WORD_W-1:0]     cpu_instruction,
    output logic                  cpu_busywait,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TG_W  = ADDR_W - IDX_W - OFF_W;

    icache_state_e            state_q;
    logic [NUM_BLOCKS-1:0]    valid_q;
    logic [TG_W-1:0]          tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]       data_q [NUM_BLOCKS];
    logic [TG_W+IDX_W-1:0]    miss_addr_q;

    logic [TG_W-1:0]          tag;
    logic [IDX_W-1:0]         idx;
    logic [1:0]               off;
    logic [IDX_W-1:0]         miss_idx;
    logic                     hit;
    logic [WORD_W-1:0]        sel_word;
    logic                     unused_byte_bits;

    assign tag              = cpu_address[ADDR_W-1 -: TG_W];
    assign idx              = cpu_address[OFF_W +: IDX_W];
    assign off              = cpu_address[OFFSET_LSB +: 2];
    assign unused_byte_bits = ^cpu_address[OFFSET_LSB-1:0];
    assign miss_idx         = miss_addr_q[IDX_W-1:0];

    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    icache_word_select u_word_select (
        .block_i  (data_q[idx]),
        .offset_i (off),
        .word_o   (sel_word)
    );

    assign cpu_instruction = hit ? sel_word : '0;
    assign mem_read        = (state_q == MEM_READ);
    assign mem_address     = miss_addr_q;

    always_comb begin
        cpu_busywait = 1'b1;
        if (state_q == IDLE) cpu_busywait = cpu_read && !hit;
    end

    // A miss is only accepted once the memory is quiet, so a refill dropped by
    // reset cannot have its late completion mistaken for the new request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_read && !hit && !mem_busywait) begin
                        miss_addr_q <= {tag, idx};
                        state_q     <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) state_q <= UPDATE;
                end
                UPDATE: begin
                    valid_q[miss_idx] <= 1'b1;
                    state_q           <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits alone gate hits.
    always_ff @(posedge clock) begin
        if (state_q == UPDATE) begin
            data_q[miss_idx] <= mem_readdata;
            tag_q[miss_idx]  <= miss_addr_q[TG_W+IDX_W-1 -: TG_W];
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised and directed bench for instruction_cache against a line-level model.
module tb_instruction_cache;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cpu_read = 1'b0;
    logic [9:0]   cpu_address = '0;
    logic [31:0]  cpu_instruction;
    logic         cpu_busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    instruction_cache dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_read        (cpu_read),
        .cpu_address     (cpu_address),
        .cpu_instruction (cpu_instruction),
        .cpu_busywait    (cpu_busywait),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_readdata    (mem_readdata),
        .mem_busywait    (mem_busywait)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction memory: word-addressed image plus a random-latency block reader.
    logic [31:0] imem [256];
    logic        mem_done = 1'b0;
    logic        stuck_busy = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 3;

    function automatic logic [127:0] blk_data(input logic [5:0] b);
        int w = int'(b) * 4;
        return {imem[w+3], imem[w+2], imem[w+1], imem[w]};
    endfunction

    assign mem_busywait = (mem_read && !mem_done) || stuck_busy;

    always @(posedge clock) begin
        if (mem_read) begin
            if (!mem_done) begin
                if (mem_cnt >= mem_lat) begin
                    mem_done     <= 1'b1;
                    mem_readdata <= blk_data(mem_address);
                end else begin
                    mem_cnt <= mem_cnt + 1;
                end
            end
        end else begin
            mem_cnt  <= 0;
            mem_done <= 1'b0;
            mem_lat  <= int'($urandom_range(1, 6));
        end
    end

    // Reference: which block address each line holds (-1 = empty).
    int line_blk [8];

    function automatic bit m_hit(input logic [9:0] a);
        return line_blk[a[6:4]] == int'(a[9:4]);
    endfunction

    function automatic logic [31:0] m_word(input logic [9:0] a);
        return imem[a[9:2]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) line_blk[i] = -1;
    endtask

    logic [5:0] refq [$];
    bit         mr_prev;

    task automatic drive(input logic rd, input logic [9:0] a);
        @(posedge clock);
        #1;
        cpu_read    = rd;
        cpu_address = a;
    endtask

    task automatic settle(input string tag);
        bit done = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (mem_read && !mr_prev) refq.push_back(mem_address);
            mr_prev = mem_read;
            if (!cpu_busywait) begin
                done = 1;
                break;
            end
        end
        if (!done) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic fetch(input logic [9:0] a, input string tag);
        bit h = m_hit(a);
        drive(1'b1, a);
        @(negedge clock);
        chk({tag, ".bw0"},  {31'd0, cpu_busywait}, {31'd0, !h});
        chk({tag, ".ins0"}, cpu_instruction, h ? m_word(a) : 32'h0);
        chk({tag, ".mr0"},  {31'd0, mem_read}, 32'd0);
        refq.delete();
        mr_prev = 1'b0;
        settle(tag);
        chk({tag, ".nref"}, refq.size(), h ? 32'd0 : 32'd1);
        if (!h && refq.size() > 0) chk({tag, ".maddr"}, {26'd0, refq[0]}, {26'd0, a[9:4]});
        if (!h) line_blk[a[6:4]] = int'(a[9:4]);
        chk({tag, ".ins"}, cpu_instruction, m_word(a));
        chk({tag, ".bw"},  {31'd0, cpu_busywait}, 32'd0);
    endtask

    task automatic reset_dut();
        drive(1'b0, 10'h000);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        bit          seen;
        logic [9:0]  a;
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        imem[0] = 32'h00030014;
        imem[1] = 32'h00040021;
        imem[2] = 32'h00010031;
        imem[3] = 32'h0A000103;
        imem[4] = 32'h0A000401;
        model_reset();

        // Held in reset with cpu_read low
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst.mr",  {31'd0, mem_read}, 32'd0);
        chk("rst.bw",  {31'd0, cpu_busywait}, 32'd0);
        chk("rst.ins", cpu_instruction, 32'h0);

        // Cold miss with reset release and cpu_read in the same cycle
        @(posedge clock);
        #1;
        reset = 1'b1; cpu_read = 1'b1; cpu_address = 10'h000;
        @(negedge clock);
        chk("cold.bw", {31'd0, cpu_busywait}, 32'd1);
        @(negedge clock);
        chk("cold.mr",    {31'd0, mem_read}, 32'd1);
        chk("cold.maddr", {26'd0, mem_address}, 32'h00);
        refq.delete(); mr_prev = 1'b1;
        settle("cold");
        line_blk[0] = 0;
        chk("cold.ins", cpu_instruction, 32'h00030014);
        chk("cold.bw1", {31'd0, cpu_busywait}, 32'd0);

        fetch(10'h004, "hit4");
        fetch(10'h008, "hit8");
        fetch(10'h00C, "hitC");
        chk("hitC.val", cpu_instruction, 32'h0A000103);
        fetch(10'h010, "seq");
        chk("seq.val", cpu_instruction, 32'h0A000401);

        // Conflict misses on index 0
        reset_dut();
        fetch(10'h000, "cf0");
        fetch(10'h080, "cf1");
        fetch(10'h000, "cf2");

        // Reset while a refill is outstanding
        drive(1'b1, 10'h020);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clock);
            seen = mem_read;
        end
        chk("mid.inread", {31'd0, seen}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0; cpu_read = 1'b0;
        model_reset();
        #1;
        chk("mid.mr", {31'd0, mem_read}, 32'd0);
        chk("mid.bw", {31'd0, cpu_busywait}, 32'd0);
        cpu_address = 10'h000;
        #1;
        chk("mid.noval", cpu_instruction, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        stuck_busy = 1'b1;
        reset = 1'b1; cpu_read = 1'b1; cpu_address = 10'h020;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("stuck.mr", {31'd0, mem_read}, 32'd0);
            chk("stuck.bw", {31'd0, cpu_busywait}, 32'd1);
        end
        stuck_busy = 1'b0;
        refq.delete(); mr_prev = 1'b0;
        settle("refetch");
        chk("refetch.nref", refq.size(), 32'd1);
        if (refq.size() > 0) chk("refetch.maddr", {26'd0, refq[0]}, 32'h02);
        chk("refetch.ins", cpu_instruction, m_word(10'h020));
        line_blk[2] = 2;
        fetch(10'h000, "after.mid");

        // Address churn while the refill for block 1 is in flight
        drive(1'b1, 10'h010);
        refq.delete(); mr_prev = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clock);
            seen = mem_read;
        end
        chk("churn.inread", {31'd0, seen}, 32'd1);
        if (seen) refq.push_back(mem_address);
        mr_prev = 1'b1;
        drive(1'b1, 10'h030);
        settle("churn");
        chk("churn.nref", refq.size(), 32'd2);
        if (refq.size() == 2) begin
            chk("churn.a0", {26'd0, refq[0]}, 32'h01);
            chk("churn.a1", {26'd0, refq[1]}, 32'h03);
        end
        line_blk[1] = 1;
        line_blk[3] = 3;
        chk("churn.ins", cpu_instruction, m_word(10'h030));
        fetch(10'h010, "churn.hit");

        // Random traffic over a small block pool so hits and conflicts both occur
        for (int it = 0; it < 120; it++) begin
            a = {6'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 19) == 0) a[9:4] = 6'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                drive(1'b0, a);
                @(negedge clock);
                chk("idle.bw",  {31'd0, cpu_busywait}, 32'd0);
                chk("idle.mr",  {31'd0, mem_read}, 32'd0);
                chk("idle.ins", cpu_instruction, m_hit(a) ? m_word(a) : 32'h0);
            end else begin
                fetch(a, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
